// File: rtl/st_align_unit.sv
// Store alignment unit: lane-replicates store data, computes byte enables and runs the
// data-memory write handshake. Define ST_RMW_EN to build read-modify-write for word-only memories.
module st_align_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_web,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        done,
  output logic        misalign,
  output logic        illegal
);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
`ifdef ST_RMW_EN
    S_READ  = 2'd3,
`endif
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [2:0]  r_func3;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_illegal;
  logic        r_misalign;

  logic        w_accept;
  logic        w_in_illegal;
  logic        w_in_misalign;
  logic        w_go;
  logic [3:0]  w_lane_en;
  logic [31:0] w_lane_data;
  logic [3:0]  w_wr_web;
  logic [31:0] w_wr_data;

  // Request decode works on the live inputs so errors are known in the accept cycle.
  assign w_accept      = req_valid && (r_state == S_IDLE);
  assign w_in_illegal  = !((func3 == F3_SB) || (func3 == F3_SH) || (func3 == F3_SW));
  assign w_in_misalign = ((func3 == F3_SH) && addr[0]) ||
                         ((func3 == F3_SW) && (addr[1:0] != 2'b00));
  assign w_go          = w_accept && !w_in_illegal && !w_in_misalign;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: request registers are plain flops (not a memory array), so they are reset; this keeps
  // dm_addr/dm_wdata at zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func3 <= 3'b000;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
    end else if (w_accept) begin
      r_func3 <= func3;
      r_addr  <= addr;
      r_data  <= st_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_illegal  <= w_accept && w_in_illegal;
      r_misalign <= w_accept && !w_in_illegal && w_in_misalign;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_lane_en   = 4'b0000;
    w_lane_data = 32'h0;
    case (r_func3)
      F3_SB: begin
        w_lane_en   = 4'b0001 << r_addr[1:0];
        w_lane_data = {4{r_data[7:0]}};
      end
      F3_SH: begin
        w_lane_en   = 4'b0011 << {r_addr[1], 1'b0};
        w_lane_data = {2{r_data[15:0]}};
      end
      F3_SW: begin
        w_lane_en   = 4'b1111;
        w_lane_data = r_data;
      end
      default: ;
    endcase
  end

`ifdef ST_RMW_EN
  logic [31:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_rdata <= 32'h0;
    else if (r_state == S_READ && dm_ack) r_rdata <= dm_rdata;
  end

  // Partial stores write the whole word: fetched bytes with the enabled lanes replaced.
  always_comb begin
    w_wr_web  = w_lane_en;
    w_wr_data = w_lane_data;
    if (w_lane_en != 4'b1111) begin
      w_wr_web = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        w_wr_data[8*i +: 8] = w_lane_en[i] ? w_lane_data[8*i +: 8] : r_rdata[8*i +: 8];
      end
    end
  end
`else
  assign w_wr_web  = w_lane_en;
  assign w_wr_data = w_lane_data;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
`ifdef ST_RMW_EN
          w_next_state = (func3 != F3_SW) ? S_READ : S_WRITE;
`else
          w_next_state = S_WRITE;
`endif
        end
      end
`ifdef ST_RMW_EN
      S_READ:  if (dm_ack) w_next_state = S_WRITE;
`endif
      S_WRITE: if (dm_ack) w_next_state = S_FIN;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_web    = 4'b0000;
    done      = 1'b0;
    case (r_state)
      S_IDLE:  req_ready = 1'b1;
`ifdef ST_RMW_EN
      S_READ:  dm_req = 1'b1;
`endif
      S_WRITE: begin
        dm_req = 1'b1;
        dm_we  = 1'b1;
        dm_web = w_wr_web;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  assign dm_addr  = {r_addr[31:2], 2'b00};
  assign dm_wdata = w_wr_data;
  assign misalign = r_misalign;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_st_align_unit.sv
// Directed bench for st_align_unit; expected values are hand-computed per vector, with the
// read-modify-write alternatives selected when ST_RMW_EN is defined.
module tb_st_align_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_web;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata = 32'h0;
  logic        dm_ack = 1'b0;
  logic        done;
  logic        misalign;
  logic        illegal;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  st_align_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .func3(func3), .addr(addr), .st_data(st_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_web(dm_web), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .done(done), .misalign(misalign), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int waits, input logic [31:0] rdata,
                           input logic partial, input logic [31:0] exp_addr,
                           input logic [3:0] exp_web, input logic [31:0] exp_wdata);
    check({tag, " ready_before"}, req_ready, 1);
    req_valid = 1'b1; func3 = f3; addr = a; st_data = d;
    step();
    req_valid = 1'b0;
`ifdef ST_RMW_EN
    if (partial) begin
      check({tag, " rd_req"}, dm_req, 1);
      check({tag, " rd_we"}, dm_we, 0);
      check({tag, " rd_web"}, dm_web, 0);
      check({tag, " rd_addr"}, dm_addr, exp_addr);
      dm_rdata = rdata;
      dm_ack = 1'b1;
      step();
      dm_ack = 1'b0;
      dm_rdata = 32'h0;
    end
`endif
    for (int i = 0; i <= waits; i++) begin
      check({tag, " req"}, dm_req, 1);
      check({tag, " we"}, dm_we, 1);
      check({tag, " web"}, dm_web, exp_web);
      check({tag, " addr"}, dm_addr, exp_addr);
      check({tag, " wdata"}, dm_wdata, exp_wdata);
      check({tag, " ready_busy"}, req_ready, 0);
      check({tag, " done_early"}, done, 0);
      if (i == waits) dm_ack = 1'b1;
      step();
    end
    dm_ack = 1'b0;
    check({tag, " done"}, done, 1);
    check({tag, " req_fin"}, dm_req, 0);
    check({tag, " ready_fin"}, req_ready, 0);
    step();
    check({tag, " done_once"}, done, 0);
    check({tag, " ready_after"}, req_ready, 1);
    check({tag, " req_idle"}, dm_req, 0);
  endtask

  task automatic run_error(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic exp_ill, input logic exp_mis);
    check({tag, " ready_before"}, req_ready, 1);
    req_valid = 1'b1; func3 = f3; addr = a; st_data = 32'hFFFF_FFFF;
    step();
    req_valid = 1'b0;
    check({tag, " illegal"}, illegal, exp_ill);
    check({tag, " misalign"}, misalign, exp_mis);
    check({tag, " no_req"}, dm_req, 0);
    check({tag, " ready"}, req_ready, 1);
    step();
    check({tag, " illegal_off"}, illegal, 0);
    check({tag, " misalign_off"}, misalign, 0);
    check({tag, " no_req2"}, dm_req, 0);
    check({tag, " no_done"}, done, 0);
  endtask

  initial begin
    #3;
    check("rst ready", req_ready, 1);
    check("rst req", dm_req, 0);
    check("rst we", dm_we, 0);
    check("rst web", dm_web, 0);
    check("rst addr", dm_addr, 0);
    check("rst wdata", dm_wdata, 0);
    check("rst done", done, 0);
    check("rst misalign", misalign, 0);
    check("rst illegal", illegal, 0);
    step();
    rst_n = 1'b1;
    step();

`ifdef ST_RMW_EN
    run_store("sb_1003", 3'b000, 32'h0000_1003, 32'h1234_56A5, 1, 32'h1122_3344, 1'b1,
              32'h0000_1000, 4'b1111, 32'hA522_3344);
    run_store("sh_2002", 3'b001, 32'h0000_2002, 32'h0000_1234, 0, 32'hDEAD_BEEF, 1'b1,
              32'h0000_2000, 4'b1111, 32'h1234_BEEF);
    run_store("sh_5000", 3'b001, 32'h0000_5000, 32'hFFFF_8001, 2, 32'h0000_0000, 1'b1,
              32'h0000_5000, 4'b1111, 32'h0000_8001);
`else
    run_store("sb_1003", 3'b000, 32'h0000_1003, 32'h1234_56A5, 1, 32'h0, 1'b1,
              32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
    run_store("sh_2002", 3'b001, 32'h0000_2002, 32'h0000_1234, 0, 32'hDEAD_BEEF, 1'b1,
              32'h0000_2000, 4'b1100, 32'h1234_1234);
    run_store("sh_5000", 3'b001, 32'h0000_5000, 32'hFFFF_8001, 2, 32'h0, 1'b1,
              32'h0000_5000, 4'b0011, 32'h8001_8001);
`endif

    run_store("sw_wait4", 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 4, 32'h0, 1'b0,
              32'h0000_3000, 4'b1111, 32'hCAFE_F00D);

    run_error("sh_mis", 3'b001, 32'h0000_1001, 1'b0, 1'b1);
    run_error("sw_mis", 3'b010, 32'h0000_1002, 1'b0, 1'b1);
    run_error("ill_011", 3'b011, 32'h0000_1000, 1'b1, 1'b0);
    run_error("ill_prio", 3'b110, 32'h0000_1003, 1'b1, 1'b0);

    // Back-to-back with zero-wait memory: run_store checks ready on every cycle between accepts.
`ifdef ST_RMW_EN
    run_store("b2b_sb", 3'b000, 32'h0000_4000, 32'h0000_007E, 0, 32'hFFFF_FFFF, 1'b1,
              32'h0000_4000, 4'b1111, 32'hFFFF_FF7E);
`else
    run_store("b2b_sb", 3'b000, 32'h0000_4000, 32'h0000_007E, 0, 32'h0, 1'b1,
              32'h0000_4000, 4'b0001, 32'h7E7E_7E7E);
`endif
    run_store("b2b_sw", 3'b010, 32'h0000_4004, 32'h89AB_CDEF, 0, 32'h0, 1'b0,
              32'h0000_4004, 4'b1111, 32'h89AB_CDEF);

    // Stray ack while idle must not start anything.
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    check("idle_ack req", dm_req, 0);
    check("idle_ack done", done, 0);
    check("idle_ack ready", req_ready, 1);

    // Reset in the middle of a write.
    req_valid = 1'b1; func3 = 3'b010; addr = 32'h0000_6000; st_data = 32'h5555_AAAA;
    step();
    req_valid = 1'b0;
    check("mid_rst pre req", dm_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst req", dm_req, 0);
    check("mid_rst we", dm_we, 0);
    check("mid_rst web", dm_web, 0);
    check("mid_rst addr", dm_addr, 0);
    check("mid_rst wdata", dm_wdata, 0);
    check("mid_rst ready", req_ready, 1);
    check("mid_rst done", done, 0);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    rst_n = 1'b1;
    check("mid_rst held done", done, 0);
    check("mid_rst held req", dm_req, 0);
    step();
    check("post_rst done", done, 0);
    run_store("post_rst_sw", 3'b010, 32'h0000_7000, 32'h0BAD_CAFE, 1, 32'h0, 1'b0,
              32'h0000_7000, 4'b1111, 32'h0BAD_CAFE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/st_align_unit.md
# st_align_unit

Store-path counterpart of the load sign/zero-extension filter; sits between the MEM stage and data memory. Takes a store request (func3, byte address, rs2 data), produces a word-aligned address, lane-replicated write data and byte-write enables, and runs the memory handshake. Misaligned and illegal stores are flagged and never reach memory. An optional mode performs read-modify-write for memories with word-only writes.

## Interface
- No parameters; data path fixed at 32 bits, 4 byte lanes.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  unit can accept a request (high only in IDLE)
- func3  in  3  000 SB, 001 SH, 010 SW; all others illegal
- addr  in  32  byte address
- st_data  in  32  rs2 value; low byte/half/word is stored
- dm_req  out  1  memory request, held until dm_ack
- dm_we  out  1  1 = write, 0 = read
- dm_web  out  4  byte write enables, bit i = lane i (bits 7:0 = lane 0)
- dm_addr  out  32  word address, {addr[31:2],2'b00}
- dm_wdata  out  32  write data
- dm_rdata  in  32  read data, valid in the dm_ack cycle of a read
- dm_ack  in  1  memory completes the current request this cycle
- done  out  1  one-cycle pulse: store committed
- misalign  out  1  one-cycle pulse: SH with addr[0]=1, or SW with addr[1:0]!=0
- illegal  out  1  one-cycle pulse: func3 not SB/SH/SW

## Operation
- Accept on req_valid && req_ready; func3, addr and st_data are registered and held until return to IDLE.
- Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
- Write data: SB {4{st_data[7:0]}}; SH {2{st_data[15:0]}}; SW st_data.
- Illegal func3 has priority over the misalignment check. Either condition: no dm_req ever asserted; matching pulse in the cycle after acceptance; back to IDLE in that same cycle.
- States: IDLE, READ (RMW only), WRITE, FIN.
- IDLE: req_ready=1, dm_req=0. On a legal, aligned accept go to WRITE, or to READ in RMW mode when dm_web != 4'b1111.
- READ: dm_req=1, dm_we=0, dm_web=0. On dm_ack, capture dm_rdata and go to WRITE.
- WRITE: dm_req=1, dm_we=1. On dm_ack go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- dm_addr, dm_we, dm_web and dm_wdata stay constant while dm_req is high; dm_ack seen in IDLE or FIN is ignored.

## Timing
- All outputs are registered. Reset values: req_ready=1; every other output 0; state IDLE.
- Accept in cycle N: dm_req high from N+1. If dm_ack arrives in cycle M, done pulses in M+1 and req_ready rises in M+2.
- Minimum store latency with zero-wait memory (ack in the first dm_req cycle) is 3 cycles from accept to next accept. An RMW partial store adds one READ phase.
- dm_ack in the first dm_req cycle is legal. Wait states are unbounded; the unit holds the request.
- Error path: accept N, pulse N+1, req_ready high again in N+1.
- An rst_n assertion mid-transaction drops dm_req asynchronously and abandons the access. No done is issued.

## Configuration
- ST_RMW_EN defined: a partial store (SB/SH) does READ then WRITE. The write uses dm_web=4'b1111 and dm_wdata = captured word with the enabled lanes replaced. SW writes directly.
- ST_RMW_EN undefined: the READ state is not built. Every store is a single WRITE with lane enables as computed; dm_we is always 1 whenever dm_req is high.

## Test plan
- SB, addr 0x0000_1003, st_data 0x1234_56A5, ack after 1 cycle -> dm_addr 0x0000_1000, dm_web 4'b1000, dm_wdata 0xA5A5_A5A5; done pulses in ack+1.
- SH, addr 0x0000_1001 -> misalign pulse in N+1; dm_req never asserted; req_ready high in N+1. func3 3'b011 -> illegal pulse, no access.
- ST_RMW_EN, SH, addr 0x0000_2002, st_data 0x0000_1234, memory word 0xDEAD_BEEF -> read of 0x0000_2000, then write 0x1234_BEEF with dm_web 4'b1111.
- SW, addr 0x0000_3000, dm_ack delayed 4 cycles -> dm_* outputs stable throughout, req_ready low; done pulses once.
- Back-to-back SB then SW with zero-wait memory -> second accept exactly 3 cycles after the first; no overlap of dm_req.
- rst_n low during WRITE -> dm_req drops immediately; all outputs at reset values; no done pulse; a new request is accepted after release.
